// File: rtl/csla_addsub_pipe.sv
// Pipelined carry-select add/sub with Z/C/N/V flags; slice k of S=WIDTH/PIPE bits resolved in stage k.
// Latency: PIPE cycles from accepted beat to out_valid; 1 beat/cycle throughput when out_ready is held high.
// Backpressure: full valid/ready stall chain, in_ready combinational from out_ready; optional saturation via CSLA_ADDSUB_SAT_EN.
module csla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
`ifdef CSLA_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v
);

    // Slice width per stage and number of carry-select blocks per slice.
    localparam int S  = WIDTH / PIPE;
    localparam int NB = S / BLOCK;

    // Per-stage valid bits and advance enables; adv[PIPE] is the consumer side.
    logic [PIPE-1:0] vld_vec;
    logic [PIPE:0]   adv;

    // Operand conditioning for stage 0: subtract inverts B and forces carry-in.
    logic [WIDTH-1:0] b_eff;
    logic             cy_eff;
    logic             sat_i;

    assign b_eff  = sub ? ~b : b;
    assign cy_eff = sub ? 1'b1 : cin;

`ifdef CSLA_ADDSUB_SAT_EN
    assign sat_i = sat;
`else
    assign sat_i = 1'b0;
`endif

    // A stage may load when it is empty or when its current beat moves on this cycle.
    always_comb begin
        adv[PIPE] = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            adv[k] = ~vld_vec[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    genvar k;
    for (k = 0; k < PIPE; k++) begin : g_st
        // Stage registers: result bits resolved so far, operands, slice carry, sign bits for overflow.
        logic             vld_q,  vld_d;
        logic [WIDTH-1:0] res_q,  res_d;
        logic [WIDTH-1:0] opa_q,  opa_d;
        logic [WIDTH-1:0] opb_q,  opb_d;
        logic             cy_q,   cy_d;
        logic             amsb_q, amsb_d;
        logic             bmsb_q, bmsb_d;
        logic             sat_q,  sat_d;

        // Values offered to this stage by its upstream neighbour.
        logic             vld_in;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] opa_in;
        logic [WIDTH-1:0] opb_in;
        logic             cy_in;
        logic             amsb_in;
        logic             bmsb_in;
        logic             sat_in;

        // Carry-select working values for this stage's slice.
        logic [WIDTH-1:0] sum_res;
        logic             sel_cy;
        logic [BLOCK:0]   s0;
        logic [BLOCK:0]   s1;

        if (k == 0) begin : g_src
            assign vld_in  = in_valid;
            assign res_in  = '0;
            assign opa_in  = a;
            assign opb_in  = b_eff;
            assign cy_in   = cy_eff;
            assign amsb_in = a[WIDTH-1];
            assign bmsb_in = b_eff[WIDTH-1];
            assign sat_in  = sat_i;
        end else begin : g_src
            assign vld_in  = g_st[k-1].vld_q;
            assign res_in  = g_st[k-1].res_q;
            assign opa_in  = g_st[k-1].opa_q;
            assign opb_in  = g_st[k-1].opb_q;
            assign cy_in   = g_st[k-1].cy_q;
            assign amsb_in = g_st[k-1].amsb_q;
            assign bmsb_in = g_st[k-1].bmsb_q;
            assign sat_in  = g_st[k-1].sat_q;
        end

        // Slice k: each block forms sum-with-0 and sum-with-1 in parallel; the carry only drives the select muxes.
        always_comb begin
            sum_res = res_in;
            sel_cy  = cy_in;
            s0      = '0;
            s1      = '0;
            for (int j = 0; j < NB; j++) begin
                s0 = {1'b0, opa_in[k*S + j*BLOCK +: BLOCK]} + {1'b0, opb_in[k*S + j*BLOCK +: BLOCK]};
                s1 = {1'b0, opa_in[k*S + j*BLOCK +: BLOCK]} + {1'b0, opb_in[k*S + j*BLOCK +: BLOCK]}
                   + {{BLOCK{1'b0}}, 1'b1};
                sum_res[k*S + j*BLOCK +: BLOCK] = sel_cy ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
                sel_cy = sel_cy ? s1[BLOCK] : s0[BLOCK];
            end
        end

        // Next state: hold while stalled, take the upstream beat when advancing; data only moves with a valid beat.
        always_comb begin
            vld_d  = vld_q;
            res_d  = res_q;
            opa_d  = opa_q;
            opb_d  = opb_q;
            cy_d   = cy_q;
            amsb_d = amsb_q;
            bmsb_d = bmsb_q;
            sat_d  = sat_q;
            if (adv[k]) begin
                vld_d = vld_in;
                if (vld_in) begin
                    res_d  = sum_res;
                    opa_d  = opa_in;
                    opb_d  = opb_in;
                    cy_d   = sel_cy;
                    amsb_d = amsb_in;
                    bmsb_d = bmsb_in;
                    sat_d  = sat_in;
                end
            end
        end

        // Stage flops; reset drops every in-flight beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                res_q  <= '0;
                opa_q  <= '0;
                opb_q  <= '0;
                cy_q   <= 1'b0;
                amsb_q <= 1'b0;
                bmsb_q <= 1'b0;
                sat_q  <= 1'b0;
            end else begin
                vld_q  <= vld_d;
                res_q  <= res_d;
                opa_q  <= opa_d;
                opb_q  <= opb_d;
                cy_q   <= cy_d;
                amsb_q <= amsb_d;
                bmsb_q <= bmsb_d;
                sat_q  <= sat_d;
            end
        end

        assign vld_vec[k] = vld_q;

        // The last stage's operand copies have no consumer; synthesis trims them back through the pipe.
        if (k == PIPE - 1) begin : g_sink
            logic unused_ops;
            assign unused_ops = ^{opa_q, opb_q};
        end
    end

    // Final-stage view.
    logic [WIDTH-1:0] res_f;
    logic             cy_f;
    logic             amsb_f;
    logic             bmsb_f;
    logic             sat_f;
    logic             vld_f;

    assign res_f  = g_st[PIPE-1].res_q;
    assign cy_f   = g_st[PIPE-1].cy_q;
    assign amsb_f = g_st[PIPE-1].amsb_q;
    assign bmsb_f = g_st[PIPE-1].bmsb_q;
    assign sat_f  = g_st[PIPE-1].sat_q;
    assign vld_f  = g_st[PIPE-1].vld_q;

    logic             ovf;
    logic [WIDTH-1:0] sat_lim;
    logic [WIDTH-1:0] y_sel;

    // Overflow from operand signs vs result sign; clamp toward the sign of A when saturation is requested.
    always_comb begin
        ovf     = (amsb_f == bmsb_f) && (res_f[WIDTH-1] != amsb_f);
        sat_lim = {amsb_f, {(WIDTH-1){~amsb_f}}};
        y_sel   = (sat_f && ovf) ? sat_lim : res_f;
    end

    // Outputs read as zero whenever no result is presented.
    assign out_valid = vld_f;
    assign y         = vld_f ? y_sel : '0;
    assign c         = vld_f & cy_f;
    assign z         = vld_f & (y_sel == '0);
    assign n         = vld_f & y_sel[WIDTH-1];
    assign v         = vld_f & ovf;

endmodule

// File: doc/csla_addsub_pipe.md
Name: csla_addsub_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit carry-select adder with zero flag used in the RV32I execute path.
- Performs WIDTH-bit add or subtract, split across PIPE register stages; each stage resolves one operand slice using carry-select blocks of BLOCK bits.
- Uses a valid/ready handshake with full backpressure and produces Z/C/N/V flags.
- Target uses: multi-cycle ALU paths and address generation at higher clock rates.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of PIPE.
- PIPE, 2, number of pipeline stages (= latency); 1..WIDTH/BLOCK; WIDTH/PIPE must be a multiple of BLOCK.
- BLOCK, 4, carry-select block width inside each stage slice.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- sub, input, 1, 1 = A-B (B inverted, carry-in forced 1); 0 = A+B+cin.
- cin, input, 1, carry-in for add; ignored when sub=1.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- y, output, WIDTH, sum/difference.
- c, output, 1, carry-out of MSB (for subtract: 1 = no borrow).
- z, output, 1, y == 0.
- n, output, 1, y[WIDTH-1].
- v, output, 1, signed overflow.

Behaviour:
- Reset is asynchronous and active-low. All stage valid bits, out_valid, y, c, z, n and v clear to 0. in_ready reads 1 once reset is released. A reset mid-operation discards all in-flight beats.
- Slice k (k = 0..PIPE-1) covers bits [(k+1)*S-1 : k*S], with S = WIDTH/PIPE.
  - Stage k adds slice k using the carry registered from stage k-1. Stage 0 uses the effective cin.
  - Stage k also registers the already-computed lower result bits and the still-unprocessed upper operand bits.
- Inside a slice, each BLOCK computes sum0/sum1 in parallel. A carry chain of select muxes picks between them. No ripple across blocks except through the muxes.
- Latency: exactly PIPE cycles from an accepted input beat (in_valid & in_ready) to out_valid, provided there is no backpressure.
- Handshake:
  - Stage k advances when it is empty, or when its contents move on in the same cycle.
  - in_ready = !valid[0] | advance[0]; this is combinational from out_ready through the chain. There is no skid buffer and no bubble insertion.
  - With out_valid=1 and out_ready=0, y and all flags hold stable and all stages stall.
  - Full throughput: 1 beat/cycle when out_ready is held 1.
  - Simultaneous input accept and output drain in the same cycle is legal with no loss.
- Flags are computed in the final stage, combinationally from the last registers, and are valid only when out_valid=1.
  - z = (y == 0).
  - n = y[MSB].
  - c = final carry.
  - v = (a[MSB] == b_eff[MSB]) & (y[MSB] != a[MSB]), where b_eff is the inverted b when sub=1. a[MSB] and b_eff[MSB] are carried down the pipe for this.
- Wrap-around: the result is modulo 2^WIDTH, with no saturation unless the optional feature is enabled.
- out_ready=1 with out_valid=0 is a no-op. in_valid may drop without having been accepted.

Optional Feature:
- Macro: CSLA_ADDSUB_SAT_EN.
- When defined:
  - An extra input port sat (1 bit) travels with each beat through the pipe.
  - If sat=1 and v=1, y is clamped to the signed limit: 0x7FFF_FFFF if a[MSB]=0, otherwise 0x8000_0000 (scaled to WIDTH).
  - z and n reflect the clamped y. c and v report the unclamped arithmetic.
  - This adds no latency.
- When undefined: the sat port is absent and y always wraps.

Test Plan:
- Reset then add, WIDTH=32, PIPE=2: a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0 -> 2 cycles later y=0x0000_0100, c=0, z=0, n=0, v=0.
- Carry across slice boundary: a=0x0000_FFFF, b=0x0000_0001 -> y=0x0001_0000. Then a=0xFFFF_FFFF, b=1 -> y=0, c=1, z=1.
- Subtract/overflow: a=0x8000_0000, b=1, sub=1 -> y=0x7FFF_FFFF, c=1, v=1, n=0. Then a=5, b=5, sub=1 -> y=0, z=1, c=1.
- Backpressure: stream 4 beats back-to-back with out_ready=0 for 3 cycles after the first out_valid -> y and flags held, in_ready=0 once the pipe is full, no beat lost or duplicated, order preserved.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately. After release, the next beat emerges alone after PIPE cycles.
- With CSLA_ADDSUB_SAT_EN defined: a=0x7FFF_FFFF, b=1, sat=1 -> y=0x7FFF_FFFF, v=1, z=0. Same inputs with sat=0 -> y=0x8000_0000, n=1.
